program_mem_ctrl: RTL and testbench

Parametrised, writable program memory for the core's instruction fetch path. Replaces the fixed-content program ROM with a RAM-backed store.
- After reset, the store is cleared to NOP (all-zero words).
- A streaming boot loader then fills it from address 0 over a valid/ready port.
- The core fetches through a one-cycle-latency request/valid port.
- Fetches are blocked while the store is being cleared or loaded.

---
 rtl/program_mem_ctrl_pkg.sv | 16 +
 rtl/program_mem_ctrl_prog_ram.sv | 25 ++
 rtl/program_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_program_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_mem_ctrl_pkg.sv
// Shared types and constants for the writable program memory.
// Holds state encoding, NOP word and default fetch-path widths.
package program_mem_ctrl_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 11;

  localparam logic [DATA_W_DEF-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_READY,
    ST_LOAD
  } state_t;

endpackage

// File: rtl/program_mem_ctrl_prog_ram.sv
// DEPTH x DATA_W array: one write port, one registered read port.
// Ports: we/waddr/wdata write, re/raddr read, rdata registered out.
module prog_ram #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 2048,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: keeps the array mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/program_mem_ctrl.sv
// RAM-backed program store: clear on reset, stream load, fetch.
// Ports: load_* boot-loader stream, fetch_* core port, busy status.
module program_mem_ctrl
  import program_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_ovf,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic              busy
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = (ADDR_W+1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              fv_q, ferr_q;
  logic              zero_q;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              accept;
  logic              in_range;
  logic              re;
  logic [DATA_W-1:0] rdata;

  assign busy       = (state_q != ST_READY);
  assign load_ready = (state_q == ST_LOAD);
  assign load_done  = done_q;
  assign load_ovf   = ovf_q;
  assign fetch_valid = fv_q;
  assign fetch_err   = ferr_q;

  assign accept   = (state_q == ST_READY) && !load_start && fetch_req;
  assign in_range = {1'b0, fetch_addr} < DEPTH_W;
  assign re       = accept && in_range;

  // zero_q forces NOP out after reset or an out-of-range fetch,
  // while the RAM read register simply holds its last word.
  assign fetch_data = zero_q ? DATA_W'(NOP) : rdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    we      = 1'b0;
    wdata   = DATA_W'(NOP);
    unique case (state_q)
      ST_CLEAR: begin
        we = 1'b1;
        if (ptr_q == LAST_W) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          ptr_d = '0;
          ovf_d = 1'b0;
        end else if (load_valid) begin
          if (ptr_q < DEPTH_W) begin
            we    = 1'b1;
            wdata = load_data;
            ptr_d = ptr_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (load_last) begin
            done_d  = 1'b1;
            state_d = ST_READY;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      fv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      fv_q    <= accept;
      ferr_q  <= accept && !in_range;
      if (accept) zero_q <= !in_range;
    end
  end

  prog_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr_q[RAM_AW-1:0]),
    .wdata (wdata),
    .re    (re),
    .raddr (fetch_addr[RAM_AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_program_mem_ctrl.sv
// Self-checking bench for program_mem_ctrl at DEPTH=16.
// Behavioural model plus directed literal checks.
module tb_program_mem_ctrl;

  localparam int DW = 14;
  localparam int AW = 11;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready, load_done, load_ovf;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid, fetch_err, busy;

  int n_checks = 0;
  int n_fail = 0;

  program_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .load_ovf    (load_ovf),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .fetch_err   (fetch_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0=clearing, 1=ready, 2=loading.
  int            m_mode = 0;
  int            m_clr = 0;
  int            m_wp = 0;
  logic [DW-1:0] m_mem [DP];
  logic          m_ovf = 0;
  logic          m_done = 0;
  logic          m_fv = 0;
  logic          m_err = 0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_clr = 0; m_ovf = 0; m_done = 0;
      m_fv = 0; m_err = 0; m_data = '0;
      for (int i = 0; i < DP; i++) m_mem[i] = '0;
    end else begin
      m_done = 0; m_fv = 0; m_err = 0;
      if (m_mode == 0) begin
        m_clr++;
        if (m_clr == DP) m_mode = 1;
      end else if (m_mode == 1) begin
        if (load_start) begin
          m_mode = 2; m_wp = 0; m_ovf = 0;
        end else if (fetch_req) begin
          m_fv = 1;
          if (int'(fetch_addr) < DP) m_data = m_mem[fetch_addr];
          else begin m_data = '0; m_err = 1; end
        end
      end else begin
        if (load_start) begin
          m_wp = 0; m_ovf = 0;
        end else if (load_valid) begin
          if (m_wp < DP) begin m_mem[m_wp] = load_data; m_wp++; end
          else m_ovf = 1;
          if (load_last) begin m_done = 1; m_mode = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_mode != 1));
    chk("load_ready", 32'(load_ready), 32'(m_mode == 2));
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("load_ovf", 32'(load_ovf), 32'(m_ovf));
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    chk("fetch_data", 32'(fetch_data), 32'(m_data));
  end

  task automatic wait_clear();
    int n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("clear_cycles", n, DP);
  endtask

  task automatic fetch_chk(input int a, input logic [DW-1:0] d,
                           input logic e);
    @(posedge clk); #1;
    fetch_req = 1; fetch_addr = AW'(a);
    @(posedge clk); #1;
    fetch_req = 0;
    @(negedge clk);
    chk("lit_fetch_valid", 32'(fetch_valid), 1);
    chk("lit_fetch_data", 32'(fetch_data), 32'(d));
    chk("lit_fetch_err", 32'(fetch_err), 32'(e));
  endtask

  task automatic start_load();
    @(posedge clk); #1 load_start = 1;
    @(posedge clk); #1 load_start = 0;
  endtask

  task automatic load_beat(input logic [DW-1:0] d, input logic last,
                           input int gap);
    @(posedge clk); #1;
    load_valid = 1; load_data = d; load_last = last;
    @(posedge clk); #1;
    load_valid = 0; load_last = 0;
    @(negedge clk);
    chk("lit_load_done", 32'(load_done), 32'(last));
    repeat (gap) @(posedge clk);
  endtask

  logic [DW-1:0] prog [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    prog[0] = 14'h3701; prog[1] = 14'h010C;
    prog[2] = 14'h3002; prog[3] = 14'h3E02;

    // 1: reset, clear pass, all zero
    repeat (3) @(posedge clk);
    chk("lit_reset_busy", 32'(busy), 1);
    chk("lit_reset_fdata", 32'(fetch_data), 0);
    #1 rst_n = 1;
    wait_clear();
    for (int i = 0; i < DP; i++) fetch_chk(i, 14'h0000, 1'b0);

    // load_start beats a same-cycle fetch
    @(posedge clk); #1;
    load_start = 1; fetch_req = 1; fetch_addr = '0;
    @(posedge clk); #1;
    load_start = 0; fetch_req = 0;
    @(negedge clk);
    chk("lit_dropped_fetch", 32'(fetch_valid), 0);
    chk("lit_in_load", 32'(load_ready), 1);

    // 2: four beats with gaps
    for (int i = 0; i < 4; i++) load_beat(prog[i], i == 3, 2);
    for (int i = 0; i < 4; i++) fetch_chk(i, prog[i], 1'b0);
    fetch_chk(4, 14'h0000, 1'b0);

    // 3: back-to-back fetches
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin fetch_req = 1; fetch_addr = AW'(i); end
      else fetch_req = 0;
      if (i > 0) begin
        @(negedge clk);
        chk("lit_b2b_valid", 32'(fetch_valid), 1);
        chk("lit_b2b_data", 32'(fetch_data), 32'(prog[i-1]));
      end
    end

    // 4: out of range
    fetch_chk(20, 14'h0000, 1'b1);
    fetch_chk(15, 14'h0000, 1'b0);

    // 5: overflow
    start_load();
    for (int i = 0; i < 18; i++) begin
      load_beat(DW'(14'h100 + i), i == 17, 0);
      if (i == 15) chk("lit_ovf_16", 32'(load_ovf), 0);
      if (i == 16) chk("lit_ovf_17", 32'(load_ovf), 1);
    end
    start_load();
    @(negedge clk);
    chk("lit_ovf_cleared", 32'(load_ovf), 0);
    load_beat(14'h2AAA, 1'b1, 0);
    fetch_chk(0, 14'h2AAA, 1'b0);
    fetch_chk(5, 14'h0105, 1'b0);
    fetch_chk(15, 14'h010F, 1'b0);

    // fetch completes despite load_start next cycle
    @(posedge clk); #1;
    fetch_req = 1; fetch_addr = '0;
    @(posedge clk); #1;
    fetch_req = 0; load_start = 1;
    @(negedge clk);
    chk("lit_fetch_then_load_v", 32'(fetch_valid), 1);
    chk("lit_fetch_then_load_d", 32'(fetch_data), 32'h2AAA);
    @(posedge clk); #1 load_start = 0;

    // 6: async reset during third beat
    load_beat(14'h1111, 1'b0, 0);
    load_beat(14'h2222, 1'b0, 0);
    @(posedge clk); #1;
    load_valid = 1; load_data = 14'h3333;
    #2 rst_n = 0;
    #1;
    chk("lit_rst_busy", 32'(busy), 1);
    chk("lit_rst_ready", 32'(load_ready), 0);
    chk("lit_rst_done", 32'(load_done), 0);
    chk("lit_rst_ovf", 32'(load_ovf), 0);
    chk("lit_rst_fvalid", 32'(fetch_valid), 0);
    chk("lit_rst_ferr", 32'(fetch_err), 0);
    chk("lit_rst_fdata", 32'(fetch_data), 0);
    load_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    wait_clear();
    for (int i = 0; i < DP; i++) fetch_chk(i, 14'h0000, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
